fft_frame_sequencer: RTL

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: buffers one accelerometer frame, streams it through an external FFT
// and reports the largest-magnitude bin of the resulting spectrum.
module fft_frame_sequencer #(
    parameter int FRAME_LEN      = 64,
    parameter int LOG2_LEN       = 6,
    parameter int SYNC_SKIP      = 0,
    parameter int TIMEOUT_FRAMES = 4,
    parameter bit SKIP_DC        = 1'b1
) (
    input  logic                sys_clock,
    input  logic                reset,
    input  logic                accel_osync,
    input  logic [7:0]          accel_data,
    output logic                fft_ce,
    output logic [15:0]         fft_sample,
    input  logic [21:0]         fft_result,
    input  logic                fft_sync,
    output logic                peak_valid,
    output logic [LOG2_LEN-1:0] peak_bin,
    output logic [11:0]         peak_mag,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err
);
    localparam int TO_LEN = TIMEOUT_FRAMES * FRAME_LEN;
    localparam int TW = $clog2(TO_LEN + 1);
    localparam int SW = $clog2(SYNC_SKIP + 2);
    localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(FRAME_LEN - 1);
    localparam logic [LOG2_LEN-1:0] LAST_BIN = LOG2_LEN'(FRAME_LEN / 2 - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LEN - 1);
    localparam logic [SW-1:0] SKIP_N = SW'(SYNC_SKIP);

    typedef enum logic [2:0] {FILL, STREAM, FLUSH, PAD, REPORT} state_t;
    state_t r_state, w_state_n;

    logic [7:0]          r_buf [FRAME_LEN];
    logic [LOG2_LEN-1:0] r_wr_ptr, r_rd_ptr, r_ce_cnt, r_bin, r_best_bin;
    logic [TW-1:0]       r_flush_cnt;
    logic [SW-1:0]       r_sync_cnt;
    logic [11:0]         r_best_mag;
    logic                r_cap, r_to;
    logic                r_fft_ce, r_peak_valid, r_busy, r_overrun, r_timeout_err;
    logic [15:0]         r_fft_sample;
    logic [LOG2_LEN-1:0] r_peak_bin;
    logic [11:0]         r_peak_mag;

    logic                w_aligned, w_start, w_cap, w_hit, w_timeout, w_done;
    logic [LOG2_LEN-1:0] w_bin, w_rd_n, w_best_bin_n;
    logic [10:0]         w_re, w_im, w_re_abs, w_im_abs;
    logic [11:0]         w_mag, w_best_mag_n;

    // the current ce cycle completes a multiple of FRAME_LEN since reset
    assign w_aligned = r_ce_cnt == LAST;
    assign w_start = (r_state == FLUSH) && !r_cap && fft_sync && (r_sync_cnt == SKIP_N);
    assign w_cap = (r_state == FLUSH) && (r_cap || w_start);
    assign w_bin = r_cap ? r_bin : '0;
    assign w_re = fft_result[21:11];
    assign w_im = fft_result[10:0];
    // an 11-bit unsigned magnitude holds 1024, so abs(-1024) cannot overflow
    assign w_re_abs = w_re[10] ? 11'(-w_re) : w_re;
    assign w_im_abs = w_im[10] ? 11'(-w_im) : w_im;
    assign w_mag = {1'b0, w_re_abs} + {1'b0, w_im_abs};
    assign w_hit = w_cap && (w_bin != '0 || !SKIP_DC) && (w_mag > (w_start ? 12'd0 : r_best_mag));
    assign w_best_mag_n = w_hit ? w_mag : (w_start ? 12'd0 : r_best_mag);
    assign w_best_bin_n = w_hit ? w_bin : (w_start ? '0 : r_best_bin);
    assign w_timeout = (r_state == FLUSH) && !w_cap && (r_flush_cnt == TO_LAST);
    assign w_done = w_cap && (w_bin == LAST_BIN);
    assign w_rd_n = (r_state == STREAM) ? r_rd_ptr + 1'b1 : '0;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            FILL:    if (accel_osync && r_wr_ptr == LAST) w_state_n = STREAM;
            STREAM:  if (r_rd_ptr == LAST) w_state_n = FLUSH;
            FLUSH:   if (w_done || w_timeout) w_state_n = w_aligned ? (w_timeout ? FILL : REPORT) : PAD;
            PAD:     if (w_aligned) w_state_n = r_to ? FILL : REPORT;
            REPORT:  w_state_n = FILL;
            default: w_state_n = FILL;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) r_state <= FILL;
        else r_state <= w_state_n;
    end

    always_ff @(posedge sys_clock) begin
        if (!reset && r_state == FILL && accel_osync) r_buf[r_wr_ptr] <= accel_data;
    end

    // outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ce_cnt      <= '0;
            r_bin         <= '0;
            r_best_bin    <= '0;
            r_best_mag    <= '0;
            r_flush_cnt   <= '0;
            r_sync_cnt    <= '0;
            r_cap         <= 1'b0;
            r_to          <= 1'b0;
            r_fft_ce      <= 1'b0;
            r_fft_sample  <= '0;
            r_peak_valid  <= 1'b0;
            r_peak_bin    <= '0;
            r_peak_mag    <= '0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_ptr      <= (r_state == FILL && accel_osync) ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr      <= w_rd_n;
            r_ce_cnt      <= r_fft_ce ? r_ce_cnt + 1'b1 : r_ce_cnt;
            r_bin         <= w_bin + 1'b1;
            r_best_bin    <= w_best_bin_n;
            r_best_mag    <= w_best_mag_n;
            r_flush_cnt   <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
            r_sync_cnt    <= (r_state != FLUSH) ? '0 :
                             (!r_cap && fft_sync && !w_start) ? r_sync_cnt + 1'b1 : r_sync_cnt;
            r_cap         <= w_cap && !w_done;
            r_to          <= (w_state_n == PAD) && (w_timeout || r_to);
            r_fft_ce      <= w_state_n inside {STREAM, FLUSH, PAD};
            r_fft_sample  <= (w_state_n == STREAM) ? {r_buf[w_rd_n], 8'd0} : '0;
            r_peak_valid  <= w_state_n == REPORT;
            r_peak_bin    <= (w_state_n == REPORT) ? w_best_bin_n : r_peak_bin;
            r_peak_mag    <= (w_state_n == REPORT) ? w_best_mag_n : r_peak_mag;
            r_busy        <= w_state_n != FILL;
            r_overrun     <= r_overrun || (accel_osync && r_state != FILL);
            r_timeout_err <= r_timeout_err || w_timeout;
        end
    end

    assign fft_ce      = r_fft_ce;
    assign fft_sample  = r_fft_sample;
    assign peak_valid  = r_peak_valid;
    assign peak_bin    = r_peak_bin;
    assign peak_mag    = r_peak_mag;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
endmodule
